mem_access_unit: RTL

Multi-cycle load/store unit between the MEM stage and a word-wide, single-port synchronous data RAM with no byte enables. It accepts the MEM-stage request (MemRead, MemWrite, MemSize, MemUnsigned, address, store data) and handles sub-word accesses. Loads are extracted and extended; sub-word stores use read-modify-write. The block holds the pipeline via Stall until the access completes.

---
 rtl/mem_access_unit.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a word-wide single-port sync RAM; sub-word stores use read-modify-write.
// Latency: loads 3, sub-word stores 4, word stores 2, misaligned 1 cycle to Done; Stall holds the pipeline until then.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Req,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            MemSize,
  input  logic                  MemUnsigned,
  input  logic [31:0]           Address,
  input  logic [31:0]           WriteData,
  output logic                  Stall,
  output logic                  Done,
  output logic [31:0]           ReadData,
  output logic                  MisalignErr,
  output logic [ADDR_WIDTH-1:0] RamAddr,
  output logic                  RamRe,
  output logic                  RamWe,
  output logic [31:0]           RamWData,
  input  logic [31:0]           RamRData
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  state_t                state_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [1:0]            offset_q;
  logic                  is_load_q;
  logic [15:0]           store_lo_q;
  logic                  done_q;
  logic                  misalign_q;
  logic [31:0]           read_data_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic                  ram_re_q;
  logic                  ram_we_q;
  logic [31:0]           ram_wdata_q;

  logic                  accept;
  logic                  req_is_byte;
  logic                  req_is_half;
  logic                  req_is_word;
  logic                  req_misalign;
  logic                  req_needs_read;
  logic [31:0]           load_ext_d;
  logic [31:0]           merged_d;
  logic                  unused_addr_bits;

  // Only the word-address field reaches the RAM; higher byte-address bits are dropped.
  assign unused_addr_bits = &{1'b0, Address[31:ADDR_WIDTH+2]};

  function automatic logic [31:0] extract_lane(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  offset,
    input logic        is_unsigned
  );
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] result;
    lane_b = 8'h00;
    case (offset)
      2'd0:    lane_b = word[31:24];
      2'd1:    lane_b = word[23:16];
      2'd2:    lane_b = word[15:8];
      default: lane_b = word[7:0];
    endcase
    lane_h = offset[1] ? word[15:0] : word[31:16];
    if (size == SZ_BYTE) begin
      result = {{24{~is_unsigned & lane_b[7]}}, lane_b};
    end else if (size == SZ_HALF) begin
      result = {{16{~is_unsigned & lane_h[15]}}, lane_h};
    end else begin
      result = word;
    end
    return result;
  endfunction

  function automatic logic [31:0] merge_lane(
    input logic [31:0] word,
    input logic [15:0] data,
    input logic [1:0]  size,
    input logic [1:0]  offset
  );
    logic [31:0] result;
    result = word;
    if (size == SZ_BYTE) begin
      case (offset)
        2'd0:    result[31:24] = data[7:0];
        2'd1:    result[23:16] = data[7:0];
        2'd2:    result[15:8]  = data[7:0];
        default: result[7:0]   = data[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      if (offset[1]) begin
        result[15:0] = data;
      end else begin
        result[31:16] = data;
      end
    end
    return result;
  endfunction

  assign accept         = ~Rst & Req & (MemRead | MemWrite);
  assign req_is_byte    = (MemSize == SZ_BYTE);
  assign req_is_half    = (MemSize == SZ_HALF);
  assign req_is_word    = ~req_is_byte & ~req_is_half;
  assign req_misalign   = (req_is_half & Address[0]) | (req_is_word & (Address[1:0] != 2'b00));
  // A word store needs no prior read; everything else goes through RD/CAP.
  assign req_needs_read = MemRead | ~req_is_word;

  assign load_ext_d = extract_lane(RamRData, size_q, offset_q, unsigned_q);
  assign merged_d   = merge_lane(RamRData, store_lo_q, size_q, offset_q);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      offset_q    <= 2'b00;
      is_load_q   <= 1'b0;
      store_lo_q  <= 16'h0000;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      read_data_q <= 32'h0000_0000;
      ram_addr_q  <= '0;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= 32'h0000_0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q     <= 1'b0;
          misalign_q <= 1'b0;
          ram_re_q   <= 1'b0;
          ram_we_q   <= 1'b0;
          if (accept) begin
            size_q     <= MemSize;
            unsigned_q <= MemUnsigned;
            offset_q   <= Address[1:0];
            is_load_q  <= MemRead;
            store_lo_q <= WriteData[15:0];
            ram_addr_q <= Address[ADDR_WIDTH+1:2];
            if (req_misalign) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              misalign_q  <= 1'b1;
              read_data_q <= 32'h0000_0000;
            end else if (req_needs_read) begin
              state_q  <= S_RD;
              ram_re_q <= 1'b1;
            end else begin
              state_q     <= S_WR;
              ram_we_q    <= 1'b1;
              ram_wdata_q <= WriteData;
            end
          end
        end
        S_RD: begin
          ram_re_q <= 1'b0;
          state_q  <= S_CAP;
        end
        S_CAP: begin
          if (is_load_q) begin
            read_data_q <= load_ext_d;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            ram_wdata_q <= merged_d;
            ram_we_q    <= 1'b1;
            state_q     <= S_WR;
          end
        end
        S_WR: begin
          ram_we_q <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q     <= 1'b0;
          misalign_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          done_q     <= 1'b0;
          misalign_q <= 1'b0;
          ram_re_q   <= 1'b0;
          ram_we_q   <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  // Stall drops in DONE so the pipeline advances on the Done cycle.
  always_comb begin
    Stall = 1'b0;
    if (!Rst) begin
      Stall = ((state_q == S_IDLE) & accept) |
              (state_q == S_RD) | (state_q == S_CAP) | (state_q == S_WR);
    end
  end

  assign Done        = done_q;
  assign MisalignErr = misalign_q;
  assign ReadData    = read_data_q;
  assign RamAddr     = ram_addr_q;
  assign RamRe       = ram_re_q;
  assign RamWe       = ram_we_q;
  assign RamWData    = ram_wdata_q;

endmodule
